// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign-fixed in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_busy;

  logic [CW-1:0]      r_count;
  logic               r_isDiv;
  logic               r_signA;
  logic               r_signB;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Operand magnitudes; the magnitude of the most negative value stays as unsigned 2^(WIDTH-1).
  logic             w_signedOp;
  logic             w_rsNeg;
  logic             w_rtNeg;
  logic [WIDTH-1:0] w_rsAbs;
  logic [WIDTH-1:0] w_rtAbs;

  assign w_signedOp = ~op[0];
  assign w_rsNeg    = w_signedOp & rs_data[WIDTH-1];
  assign w_rtNeg    = w_signedOp & rt_data[WIDTH-1];
  assign w_rsAbs    = w_rsNeg ? -rs_data : rs_data;
  assign w_rtAbs    = w_rtNeg ? -rt_data : rt_data;

  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulStep;
  logic [WIDTH:0]     w_divUpper;
  logic [WIDTH:0]     w_trial;
  logic               w_divOk;
  logic [2*WIDTH-1:0] w_divStep;

  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mulStep = {w_mulSum, r_acc[WIDTH-1:1]};

  // The partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  assign w_divUpper = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_divUpper - {1'b0, r_b};
  assign w_divOk    = ~w_trial[WIDTH];
  assign w_divStep  = {(w_divOk ? w_trial[WIDTH-1:0] : w_divUpper[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_divOk};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod = (r_signA ^ r_signB) ? -r_acc : r_acc;
  assign w_quot = (r_signA ^ r_signB) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_signA ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_CALC;
      end
      S_CALC: if (r_count == LAST_COUNT) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: begin
        w_next = S_IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_divZero <= 1'b0;
      r_b       <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start takes priority and drops any simultaneous move-to write.
          if (start) begin
            r_isDiv   <= op[1];
            r_signA   <= w_rsNeg;
            r_signB   <= w_rtNeg;
            r_divZero <= (rt_data == '0);
            r_b       <= op[1] ? w_rtAbs : w_rsAbs;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_rsAbs : w_rtAbs)};
            r_count   <= '0;
          end else begin
            if (mthi) r_hi <= mt_data;
            if (mtlo) r_lo <= mt_data;
          end
        end
        S_CALC: begin
          r_acc   <= r_isDiv ? w_divStep : w_mulStep;
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          if (r_isDiv) begin
            r_hi <= w_rem;
            r_lo <= r_divZero ? {WIDTH{1'b1}} : w_quot;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations scored
// against an arithmetic reference model of the MIPS HI/LO semantics.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int totalChecks = 0;
  int badChecks   = 0;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .mt_data (mt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // MIPS semantics with plain integer arithmetic: truncating division, remainder takes dividend sign.
  function automatic void refModel(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eHi, output logic [31:0] eLo);
    longint      sp;
    logic [63:0] p;
    int          sa;
    int          sb;
    sa = $signed(a);
    sb = $signed(b);
    eHi = '0;
    eLo = '0;
    case (opIn)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        p  = 64'(sp);
        {eHi, eLo} = p;
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        {eHi, eLo} = p;
      end
      2'b10: begin
        if (b == 32'd0) begin
          eHi = a; eLo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eHi = 32'd0; eLo = 32'h8000_0000;
        end else begin
          eLo = 32'(sa / sb);
          eHi = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 32'd0) begin
          eHi = a; eLo = 32'hFFFF_FFFF;
        end else begin
          eLo = a / b;
          eHi = a % b;
        end
      end
    endcase
  endfunction

  // mode 0: plain, 1: start/mthi pulse mid-operation, 2: mthi/mtlo driven with start.
  task automatic applyStimulus(input string tag, input logic [1:0] opIn, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                               input int mode, input bit immediate);
    int n;
    int busyCycles;
    bit seen;
    if (!immediate) @(negedge clk);
    start = 1'b1; op = opIn; rs_data = a; rt_data = b;
    if (mode == 2) begin
      mthi = 1'b1; mtlo = 1'b1; mt_data = $urandom;
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
    n = 0; busyCycles = 0; seen = 1'b0;
    while (n < 60 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busyCycles++;
        if (n == 0 || n == 16) begin
          checkOutput({tag, "/holdHi"}, hi, modelHi);
          checkOutput({tag, "/holdLo"}, lo, modelLo);
        end
        if (mode == 1 && n == 9) begin
          start = 1'b1; op = 2'b10; mthi = 1'b1; mt_data = 32'hAA;
        end
        if (mode == 1 && n == 10) begin
          start = 1'b0; mthi = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    checkOutput({tag, "/doneSeen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "/latency"}, 32'(n), 32'd33);
      checkOutput({tag, "/busyCycles"}, 32'(busyCycles), 32'd33);
      checkOutput({tag, "/busyAtDone"}, 32'(busy), 32'd0);
      checkOutput({tag, "/hi"}, hi, expHi);
      checkOutput({tag, "/lo"}, lo, expLo);
    end
    modelHi = expHi;
    modelLo = expLo;
  endtask

  task automatic runModelled(input string tag, input logic [1:0] opIn, input logic [31:0] a,
                             input logic [31:0] b, input bit immediate);
    logic [31:0] eHi;
    logic [31:0] eLo;
    refModel(opIn, a, b, eHi, eLo);
    applyStimulus(tag, opIn, a, b, eHi, eLo, 0, immediate);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; mt_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset/busy", 32'(busy), 32'd0);
    checkOutput("reset/done", 32'(done), 32'd0);
    checkOutput("reset/hi", hi, 32'd0);
    checkOutput("reset/lo", lo, 32'd0);
    reset = 1'b1;

    applyStimulus("multuMax", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
    applyStimulus("multNeg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b1);
    applyStimulus("multMin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 1'b0);
    applyStimulus("divNeg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b1);
    applyStimulus("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b0);
    applyStimulus("divuZero", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 0, 1'b0);
    applyStimulus("divOvf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 1'b1);
    applyStimulus("divZeroNeg", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 1'b0);

    // Busy-time start and mthi must both be dropped.
    applyStimulus("ignoreBusy", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1, 1'b0);
    @(negedge clk);
    mtlo = 1'b1; mt_data = 32'h55;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mtlo/lo", lo, 32'h55);
    checkOutput("mtlo/hi", hi, 32'h0);
    modelLo = 32'h55;

    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checkOutput("mtBoth/hi", hi, 32'hDEAD_BEEF);
    checkOutput("mtBoth/lo", lo, 32'hDEAD_BEEF);
    modelHi = 32'hDEAD_BEEF;
    modelLo = 32'hDEAD_BEEF;

    applyStimulus("startWinsMt", 2'b01, 32'd9, 32'd9, 32'd0, 32'd81, 2, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 2'($urandom);
      ra  = pickOperand();
      rb  = pickOperand();
      runModelled($sformatf("rand%0d", i), rop, ra, rb, 1'(i % 2));
    end

    // Asynchronous abort in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort/busy", 32'(busy), 32'd0);
    checkOutput("abort/done", 32'(done), 32'd0);
    checkOutput("abort/hi", hi, 32'd0);
    checkOutput("abort/lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    modelHi = '0;
    modelLo = '0;
    applyStimulus("afterAbort", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
